// File: rtl/cordic_sincos_iter_if.sv
// Start/busy/done handshake and result bus of the iterative CORDIC sin/cos engine.
interface cordic_sincos_iter_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ANGLE_WIDTH = 16
);
  logic                         i_start;
  logic [ANGLE_WIDTH-1:0]       i_angle;
  logic                         o_busy;
  logic                         o_done;
  logic signed [DATA_WIDTH-1:0] o_out_x;
  logic signed [DATA_WIDTH-1:0] o_out_y;

  modport master (
    output i_start, i_angle,
    input  o_busy, o_done, o_out_x, o_out_y
  );

  modport slave (
    input  i_start, i_angle,
    output o_busy, o_done, o_out_x, o_out_y
  );
endinterface

// File: rtl/cordic_sincos_iter.sv
// Full-circle iterative CORDIC rotator: folds the phase to one quadrant, rotates a
// gain-precompensated unit vector, then maps the quadrant back to signed cos/sin.
module cordic_sincos_iter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ANGLE_WIDTH = 16,
  parameter int unsigned ITERATIONS  = 14,
  parameter int unsigned GUARD_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  cordic_sincos_iter_if.slave   bus
);

  localparam int unsigned XW = DATA_WIDTH + GUARD_BITS;
  localparam int unsigned ZW = ANGLE_WIDTH + GUARD_BITS;
  localparam int unsigned CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int unsigned TABLE_DEPTH = 2 ** CW;
  localparam real PI = 3.14159265358979323846;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // atan(2^-i) in z units where a quarter turn is 2^(ANGLE_WIDTH-2+GUARD_BITS)
  function automatic int atan_const(input int i);
    real v;
    v = $atan(2.0 ** (-i)) * (2.0 ** (ANGLE_WIDTH - 2 + GUARD_BITS)) / (PI / 2.0);
    return $rtoi(v + 0.5);
  endfunction

  // Inverse CORDIC gain applied to the start vector so no output scaling is needed
  function automatic int k_init();
    real k;
    k = 1.0;
    for (int i = 0; i < int'(ITERATIONS); i++) begin
      k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    return $rtoi(k * (2.0 ** (DATA_WIDTH - 2 + GUARD_BITS)) + 0.5);
  endfunction

  localparam logic signed [XW-1:0] X_INIT = XW'(k_init());

  logic signed [ZW-1:0] w_atan [TABLE_DEPTH];

  for (genvar g = 0; g < int'(TABLE_DEPTH); g++) begin : g_atan
    if (g < int'(ITERATIONS)) begin : g_used
      assign w_atan[g] = ZW'(atan_const(g));
    end else begin : g_pad
      assign w_atan[g] = '0;
    end
  end

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [CW-1:0]        r_count;
  logic [1:0]           r_quad;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic                 r_busy;
  logic                 r_done;
  logic signed [DATA_WIDTH-1:0] r_out_x;
  logic signed [DATA_WIDTH-1:0] r_out_y;

  logic signed [XW-1:0] w_x_sh;
  logic signed [XW-1:0] w_y_sh;
  logic signed [XW-1:0] w_map_x;
  logic signed [XW-1:0] w_map_y;
  logic signed [DATA_WIDTH-1:0] w_trunc_x;
  logic signed [DATA_WIDTH-1:0] w_trunc_y;
  logic                 w_dir_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.i_start) w_next_state = S_ROTATE;
      S_ROTATE:       if (r_count == CW'(ITERATIONS - 1)) w_next_state = S_FINISH;
      S_FINISH:       w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // Micro-rotation operands and final quadrant unfolding
  always_comb begin
    w_x_sh    = r_x >>> r_count;
    w_y_sh    = r_y >>> r_count;
    w_dir_pos = ~r_z[ZW-1];
    w_map_x   = r_x;
    w_map_y   = r_y;
    case (r_quad)
      2'd1:    begin w_map_x = -r_y; w_map_y =  r_x; end
      2'd2:    begin w_map_x = -r_x; w_map_y = -r_y; end
      2'd3:    begin w_map_x =  r_y; w_map_y = -r_x; end
      default: begin w_map_x =  r_x; w_map_y =  r_y; end
    endcase
    w_trunc_x = DATA_WIDTH'(w_map_x >>> GUARD_BITS);
    w_trunc_y = DATA_WIDTH'(w_map_y >>> GUARD_BITS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_quad  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out_x <= '0;
      r_out_y <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            r_quad  <= bus.i_angle[ANGLE_WIDTH-1:ANGLE_WIDTH-2];
            r_z     <= ZW'({bus.i_angle[ANGLE_WIDTH-3:0], {GUARD_BITS{1'b0}}});
            r_x     <= X_INIT;
            r_y     <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_ROTATE: begin
          if (w_dir_pos) begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan[r_count];
          end else begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan[r_count];
          end
          r_count <= r_count + CW'(1);
        end
        S_FINISH: begin
          r_out_x <= w_trunc_x;
          r_out_y <= w_trunc_y;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_out_x = r_out_x;
  assign bus.o_out_y = r_out_y;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Self-checking bench for cordic_sincos_iter against a real-arithmetic cos/sin model.
module tb_cordic_sincos_iter;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned IT  = 14;
  localparam int unsigned GB  = 3;
  localparam int          TOL = 4;
  localparam int          N_RAND = 2000;
  localparam real         PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  cordic_sincos_iter_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) bus ();

  cordic_sincos_iter #(
    .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .ITERATIONS(IT), .GUARD_BITS(GB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    n_checks++;
    if ((obs - exp > tol) || (exp - obs > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Ideal rounded cos/sin at +1.0 = 2^(DW-2)
  function automatic int ideal(input logic [AW-1:0] a, input bit is_sin);
    real ph;
    real v;
    ph = 2.0 * PI * real'(a) / (2.0 ** AW);
    v  = is_sin ? $sin(ph) : $cos(ph);
    return int'(v * (2.0 ** (DW - 2)));
  endfunction

  // Issue one start at a negedge, wait bounded for done, check latency, busy and result
  task automatic run_one(input logic [AW-1:0] a, input string tag);
    int lat;
    int gaps;
    bus.i_start = 1'b1;
    bus.i_angle = a;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat  = 0;
    gaps = 0;
    while (!bus.o_done && lat < 40) begin
      if (!bus.o_busy) gaps++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, int'(IT) + 1);
    check({tag, "_busy"}, gaps, 0);
    check({tag, "_x"}, int'(bus.o_out_x), ideal(a, 1'b0), TOL);
    check({tag, "_y"}, int'(bus.o_out_y), ideal(a, 1'b1), TOL);
  endtask

  logic [AW-1:0] dir_angles [8];
  string         dir_tags   [8];

  initial begin
    int rises;
    int accepts;
    int cyc;
    int old_x;
    int old_y;
    bit prev;
    logic [AW-1:0] a;
    logic [AW-1:0] q[$];

    dir_angles = '{16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hE000, 16'hFFFF, 16'h0001, 16'h7FFF};
    dir_tags   = '{"q1_axis", "q2_axis", "q3_axis", "pi4", "m_pi4", "wrap_ffff", "tiny", "q1_edge"};

    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_angle = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_x", int'(bus.o_out_x), 0);
    check("rst_y", int'(bus.o_out_y), 0);
    reset = 1'b0;
    @(negedge clk);

    run_one(16'h1000, "pre_rst");

    // Reset arriving while iteration 5 is in flight
    bus.i_start = 1'b1;
    bus.i_angle = 16'h6000;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", int'(bus.o_busy), 0);
    check("midrst_done", int'(bus.o_done), 0);
    check("midrst_x", int'(bus.o_out_x), 0);
    check("midrst_y", int'(bus.o_out_y), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_one(16'h0000, "ang0");
    for (int i = 0; i < 8; i++) run_one(dir_angles[i], dir_tags[i]);

    // Starts during a busy computation must be ignored
    bus.i_start = 1'b1;
    bus.i_angle = 16'h1555;
    @(negedge clk);
    rises = 0;
    prev  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 7) begin
        bus.i_start = 1'b1;
        bus.i_angle = 16'h9999;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      if (bus.o_done && !prev) rises++;
      prev = bus.o_done;
    end
    check("busy_ign_rises", rises, 1);
    check("busy_ign_hold", int'(bus.o_done), 1);
    check("busy_ign_x", int'(bus.o_out_x), ideal(16'h1555, 1'b0), TOL);
    check("busy_ign_y", int'(bus.o_out_y), ideal(16'h1555, 1'b1), TOL);

    // Start from DONE: done drops, outputs keep the old result until the new one
    old_x = int'(bus.o_out_x);
    old_y = int'(bus.o_out_y);
    bus.i_start = 1'b1;
    bus.i_angle = 16'h5800;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("redo_done", int'(bus.o_done), 0);
    check("redo_busy", int'(bus.o_busy), 1);
    check("redo_oldx", int'(bus.o_out_x), old_x);
    check("redo_oldy", int'(bus.o_out_y), old_y);
    cyc = 0;
    while (!bus.o_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("redo_lat", cyc, int'(IT) + 1);
    check("redo_x", int'(bus.o_out_x), ideal(16'h5800, 1'b0), TOL);
    check("redo_y", int'(bus.o_out_y), ideal(16'h5800, 1'b1), TOL);

    // Back-to-back random angles with start held high
    accepts = 0;
    rises   = 0;
    cyc     = 0;
    prev    = bus.o_done;
    while ((accepts < N_RAND || q.size() > 0) && cyc < N_RAND * (int'(IT) + 2) + 200) begin
      if (bus.o_done && !prev) begin
        rises++;
        if (q.size() == 0) begin
          check("rand_spurious_done", 1, 0);
        end else begin
          a = q.pop_front();
          check("rand_x", int'(bus.o_out_x), ideal(a, 1'b0), TOL);
          check("rand_y", int'(bus.o_out_y), ideal(a, 1'b1), TOL);
        end
      end
      prev = bus.o_done;
      if (accepts < N_RAND) begin
        bus.i_start = 1'b1;
        bus.i_angle = AW'($urandom);
        if (!bus.o_busy) begin
          q.push_back(bus.i_angle);
          accepts++;
        end
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("rand_accepts", accepts, N_RAND);
    check("rand_rises", rises, accepts);
    check("rand_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
